// File: rtl/hamming_sec_decoder_pkg.sv
// Shared constants, result type and Hamming helper functions for the
// 38/32 single-error-correcting decode path.
package hamming_pkg;

    localparam int CODE_W  = 38;
    localparam int DATA_W  = 32;
    localparam int PAR_W   = 6;
    localparam int MAX_POS = 38;

    // One decoded word as it leaves the second pipeline stage.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PAR_W-1:0]  syndrome;
        logic              corrected;
        logic              uncorrectable;
    } dec_result_t;

    // Pull the 32 data bits out of the non-power-of-two positions.
    // Index i of the codeword holds Hamming position i+1.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        return {code[37:32], code[30:16], code[14:8], code[6:4], code[2]};
    endfunction

    // XOR of the position numbers of every set bit; zero for a clean word,
    // otherwise the position of a single flipped bit.
    function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
        logic [PAR_W-1:0] syn;
        syn = '0;
        for (int p = 1; p <= MAX_POS; p++) begin
            if (code[PAR_W'(p - 1)]) begin
                syn = syn ^ PAR_W'(p);
            end
        end
        return syn;
    endfunction

endpackage

// File: rtl/hamming_sec_decoder_if.sv
// Codeword-in / decoded-word-out stream bundle for the SEC decoder.
interface hamming_sec_decoder_if;
    import hamming_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in_code;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [PAR_W-1:0]    out_syndrome;
    logic                out_corrected;
    logic                out_uncorrectable;

    // Producer of codewords and consumer of decoded words.
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable
    );

    // The decoder itself.
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable
    );

endinterface

// File: rtl/hamming_sec_decoder_syndrome.sv
// Purely combinational syndrome generator; also usable by the encoder's
// self-check, so it has no clock or handshake.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  syndrome
);

    // Syndrome follows the codeword with no state.
    always_comb begin
        syndrome = calc_syndrome(code);
    end

endmodule

// File: rtl/hamming_sec_decoder.sv
// Two-stage Hamming SEC decoder: S1 holds the codeword and its syndrome,
// S2 holds the corrected data with status flags. Saturating counters tally
// corrected and uncorrectable words as they are delivered.
module hamming_sec_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_sec_decoder_if.slave  bus,
    input  logic                  clr_counts,
    output logic [CNT_W-1:0]      corr_count,
    output logic [CNT_W-1:0]      uncorr_count
);

    logic                s1_valid;
    logic [CODE_W-1:0]   s1_code;
    logic [PAR_W-1:0]    s1_syndrome;
    logic [PAR_W-1:0]    syndrome_w;
    logic                out_valid_q;
    dec_result_t         out_q;
    dec_result_t         fix;
    logic [CODE_W-1:0]   corr_mask;
    logic                s2_advance;
    logic                in_ready_w;
    logic                out_xfer;

    hamming_syndrome u_syndrome (
        .code     (bus.in_code),
        .syndrome (syndrome_w)
    );

    // S2 moves when it is empty or its word is being taken; S1 can take a
    // new word when it is empty or is handing its word to S2.
    always_comb begin
        s2_advance = !out_valid_q || bus.out_ready;
        in_ready_w = !s1_valid || s2_advance;
        out_xfer   = out_valid_q && bus.out_ready;
    end

    // Stage 1 captures the incoming codeword together with its syndrome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_code     <= '0;
            s1_syndrome <= '0;
        end else if (in_ready_w) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_code     <= bus.in_code;
                s1_syndrome <= syndrome_w;
            end
        end
    end

    // Flip the single bit named by the syndrome (positions 1..38 only) and
    // classify the word; syndromes past 38 leave the codeword untouched.
    always_comb begin
        corr_mask = '0;
        fix       = '0;
        for (int i = 0; i < CODE_W; i++) begin
            corr_mask[i] = (s1_syndrome == PAR_W'(i + 1));
        end
        fix.data          = extract_data(s1_code ^ corr_mask);
        fix.syndrome      = s1_syndrome;
        fix.corrected     = (s1_syndrome != '0) && (s1_syndrome <= PAR_W'(MAX_POS));
        fix.uncorrectable = (s1_syndrome > PAR_W'(MAX_POS));
    end

    // Stage 2 holds the decoded word stable until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (s2_advance) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_q <= fix;
            end
        end
    end

    // Corrected-word tally: clear wins over a same-cycle increment, and the
    // count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count <= '0;
        end else if (clr_counts) begin
            corr_count <= '0;
        end else if (out_xfer && out_q.corrected && (corr_count != '1)) begin
            corr_count <= corr_count + CNT_W'(1);
        end
    end

    // Uncorrectable-word tally with the same clear and saturation rules.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uncorr_count <= '0;
        end else if (clr_counts) begin
            uncorr_count <= '0;
        end else if (out_xfer && out_q.uncorrectable && (uncorr_count != '1)) begin
            uncorr_count <= uncorr_count + CNT_W'(1);
        end
    end

    assign bus.in_ready          = in_ready_w;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_q.data;
    assign bus.out_syndrome      = out_q.syndrome;
    assign bus.out_corrected     = out_q.corrected;
    assign bus.out_uncorrectable = out_q.uncorrectable;

endmodule

// File: tb/tb_hamming_sec_decoder.sv
// Directed bench for hamming_sec_decoder: expected words go into a queue when
// a codeword is accepted and are compared when the decoder hands a word over.
module tb_hamming_sec_decoder;
    import hamming_pkg::*;

    localparam int CNT_W = 16;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  syn;
        logic        corr;
        logic        uncorr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr_counts = 1'b0;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    int   check_count = 0;
    int   pass_count  = 0;
    int   delivered   = 0;
    exp_t sb[$];

    hamming_sec_decoder_if bus();

    hamming_sec_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_counts   (clr_counts),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [5:0] s,
                                input logic c, input logic u);
        exp_t e;
        e.data = d; e.syn = s; e.corr = c; e.uncorr = u;
        return e;
    endfunction

    // Reference decoder built bit-by-bit from the position numbering.
    function automatic exp_t model(input logic [37:0] code);
        exp_t        e;
        logic [37:0] c;
        logic [5:0]  s;
        int          j;
        s = '0;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 38; i++)
                if ((((i + 1) >> k) & 1) == 1) s[k] = s[k] ^ code[i];
        c = code;
        if (s >= 6'd1 && s <= 6'd38) c[s - 6'd1] = ~c[s - 6'd1];
        e.data = '0;
        j = 0;
        for (int p = 1; p <= 38; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
                e.data[j] = c[p - 1];
                j++;
            end
        end
        e.syn    = s;
        e.corr   = (s != 6'd0) && (s <= 6'd38);
        e.uncorr = (s > 6'd38);
        return e;
    endfunction

    // Present one codeword until accepted, then queue its expected result.
    task automatic applyStimulus(input logic [37:0] code, input exp_t e);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            n++;
        end
        if (!acc) checkOutput("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        else sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare every word the consumer takes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            delivered++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_word", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
                checkOutput("out_syndrome", {58'd0, bus.out_syndrome}, {58'd0, e.syn});
                checkOutput("out_corrected", {63'd0, bus.out_corrected}, {63'd0, e.corr});
                checkOutput("out_uncorrectable", {63'd0, bus.out_uncorrectable}, {63'd0, e.uncorr});
            end
        end
    end

    initial begin
        logic [37:0] c;
        logic [37:0] bp_codes[4];
        logic [5:0]  hi;
        logic [31:0] lo;
        int          d0;
        exp_t        w0;

        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #3;
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        checkOutput("rst_out_syndrome", {58'd0, bus.out_syndrome}, 64'd0);
        checkOutput("rst_flags", {62'd0, bus.out_corrected, bus.out_uncorrectable}, 64'd0);
        checkOutput("rst_corr_count", {48'd0, corr_count}, 64'd0);
        checkOutput("rst_uncorr_count", {48'd0, uncorr_count}, 64'd0);
        #19 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Clean word and latency
        applyStimulus(38'h7, mk(32'h1, 6'd0, 1'b0, 1'b0));
        checkOutput("lat_s1_only", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk); #1;
        checkOutput("lat_out_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("lat_out_data", {32'd0, bus.out_data}, 64'd1);
        drain(2);
        checkOutput("clean_corr_count", {48'd0, corr_count}, 64'd0);

        // Single data-bit error
        applyStimulus(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
        drain(3);
        checkOutput("single_corr_count", {48'd0, corr_count}, 64'd1);

        // Parity-bit error at position 32
        c = '0; c[31] = 1'b1;
        applyStimulus(c, mk(32'h0, 6'd32, 1'b1, 1'b0));
        drain(3);
        checkOutput("parity_corr_count", {48'd0, corr_count}, 64'd2);

        // Double error landing on syndrome 41: position 33 passes through as data[26]
        c = '0; c[32] = 1'b1; c[7] = 1'b1;
        applyStimulus(c, mk(32'h0400_0000, 6'd41, 1'b0, 1'b1));
        drain(3);
        checkOutput("uncorr_count_1", {48'd0, uncorr_count}, 64'd1);

        // Boundary syndromes 38 (last correctable) and 39 (first uncorrectable)
        c = '0; c[37] = 1'b1;
        applyStimulus(c, mk(32'h0, 6'd38, 1'b1, 1'b0));
        c = '0; c[37] = 1'b1; c[0] = 1'b1;
        applyStimulus(c, mk(32'h8000_0000, 6'd39, 1'b0, 1'b1));
        drain(3);
        checkOutput("bound_corr_count", {48'd0, corr_count}, 64'd3);
        checkOutput("bound_uncorr_count", {48'd0, uncorr_count}, 64'd2);

        // Random codewords, back to back
        for (int i = 0; i < 8; i++) begin
            hi = 6'($urandom_range(63, 0));
            lo = $urandom();
            c  = {hi, lo};
            applyStimulus(c, model(c));
        end
        drain(3);

        // Backpressure: four words, consumer stalled for five cycles
        for (int i = 0; i < 4; i++) begin
            hi = 6'($urandom_range(63, 0));
            lo = $urandom();
            bp_codes[i] = {hi, lo};
        end
        w0 = model(bp_codes[0]);
        d0 = delivered;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(bp_codes[i], model(bp_codes[i]));
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                checkOutput("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
                checkOutput("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
                repeat (3) begin
                    @(posedge clk); #2;
                    checkOutput("bp_hold_data", {32'd0, bus.out_data}, {32'd0, w0.data});
                    checkOutput("bp_hold_syndrome", {58'd0, bus.out_syndrome}, {58'd0, w0.syn});
                    checkOutput("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain(4);
        checkOutput("bp_delivered", 64'(delivered - d0), 64'd4);
        checkOutput("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        applyStimulus(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
        applyStimulus(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
        checkOutput("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("async_rst_corr", {48'd0, corr_count}, 64'd0);
        checkOutput("async_rst_uncorr", {48'd0, uncorr_count}, 64'd0);
        checkOutput("async_rst_out_data", {32'd0, bus.out_data}, 64'd0);
        sb.delete();
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("rerst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("rerst_flushed", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk); #1;
        checkOutput("rerst_still_empty", {63'd0, bus.out_valid}, 64'd0);

        // Saturation of the corrected-word counter
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            applyStimulus(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
        end
        drain(3);
        checkOutput("sat_corr_count", {48'd0, corr_count}, {48'd0, {CNT_W{1'b1}}});
        checkOutput("sat_uncorr_count", {48'd0, uncorr_count}, 64'd0);

        // Clear concurrent with a corrected transfer
        applyStimulus(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
        @(posedge clk); #1;
        checkOutput("clr_out_valid", {63'd0, bus.out_valid}, 64'd1);
        clr_counts = 1'b1;
        @(posedge clk); #1;
        clr_counts = 1'b0;
        checkOutput("clr_priority", {48'd0, corr_count}, 64'd0);
        applyStimulus(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
        drain(3);
        checkOutput("post_clr_count", {48'd0, corr_count}, 64'd1);

        drain(2);
        checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
